// File: rtl/oh2b_chk.sv
// oh2b_chk: registers one-hot words from the b2oh decoder, encodes them back
// to binary, flags malformed codes and keeps saturating error/accept counters.
// Valid/ready handshake with one cycle of latency and full throughput.
module oh2b_chk #(
    parameter int N  = 3,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] positional,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    binary,
    output logic            err,
    output logic            sticky_err,
    output logic [CW-1:0]   err_cnt,
    output logic [CW-1:0]   acc_cnt
);

    localparam int W = 2**N;

    logic          accept;
    logic [N-1:0]  enc;
    logic          bad;
    logic [CW-1:0] err_base, acc_base;
    logic [CW-1:0] err_nxt, acc_nxt;
    logic          sticky_nxt;

    // Ready whenever the output slot is empty or draining; forced high during
    // reset because the held result is about to be discarded anyway.
    assign in_ready = !rst_n || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Lowest-set-bit encoder plus malformed detect (none set, or more than one).
    always_comb begin
        enc = '0;
        for (int i = W-1; i >= 0; i--) begin
            if (positional[i]) enc = N'(i);
        end
        bad = (positional == '0) || ((positional & (positional - 1'b1)) != '0);
    end

    // Counter next-state: clear first, then count the same-cycle accept on top.
    always_comb begin
        err_base   = clr ? '0 : err_cnt;
        acc_base   = clr ? '0 : acc_cnt;
        err_nxt    = err_base;
        acc_nxt    = acc_base;
        sticky_nxt = clr ? 1'b0 : sticky_err;
        if (accept) begin
            acc_nxt = (&acc_base) ? acc_base : acc_base + CW'(1);
            if (bad) begin
                err_nxt    = (&err_base) ? err_base : err_base + CW'(1);
                sticky_nxt = 1'b1;
            end
        end
    end

    // Output slot: load on accept, empty on transfer without accept, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            binary    <= '0;
            err       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            binary    <= enc;
            err       <= bad;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            acc_cnt    <= '0;
            sticky_err <= 1'b0;
        end else begin
            err_cnt    <= err_nxt;
            acc_cnt    <= acc_nxt;
            sticky_err <= sticky_nxt;
        end
    end

endmodule

// File: tb/tb_oh2b_chk.sv
// Directed-vector bench for oh2b_chk (N=3, CW=4 so saturation is reachable).
module tb_oh2b_chk;

    localparam int N  = 3;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n, clr, in_valid, in_ready, out_valid, out_ready;
    logic [2**N-1:0] positional;
    logic [N-1:0]    binary;
    logic            err, sticky_err;
    logic [CW-1:0]   err_cnt, acc_cnt;

    int errors = 0;
    int checks = 0;

    oh2b_chk #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .positional(positional),
        .out_valid(out_valid), .out_ready(out_ready),
        .binary(binary), .err(err), .sticky_err(sticky_err),
        .err_cnt(err_cnt), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; positional = '0;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_binary", binary, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", sticky_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_acc_cnt", acc_cnt, 0);
        rst_n = 1'b1;

        // Sweep all legal one-hot codes back to back.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            positional = 8'(1 << i);
            step();
            chk($sformatf("sweep_bin%0d", i), binary, i);
            chk($sformatf("sweep_err%0d", i), err, 0);
            chk($sformatf("sweep_vld%0d", i), out_valid, 1);
        end
        in_valid = 1'b0;
        step();
        chk("sweep_drain_vld", out_valid, 0);
        chk("sweep_acc", acc_cnt, 8);
        chk("sweep_errcnt", err_cnt, 0);
        chk("sweep_sticky", sticky_err, 0);

        // Malformed words.
        in_valid = 1'b1; positional = 8'b0000_0000;
        step();
        chk("zero_bin", binary, 0);
        chk("zero_err", err, 1);
        positional = 8'b0010_0100;
        step();
        chk("multi_bin", binary, 2);
        chk("multi_err", err, 1);
        in_valid = 1'b0;
        step();
        chk("mal_errcnt", err_cnt, 2);
        chk("mal_acc", acc_cnt, 10);
        chk("mal_sticky", sticky_err, 1);

        // Backpressure.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_errcnt", err_cnt, 0);
        chk("clr_acc", acc_cnt, 0);
        chk("clr_sticky", sticky_err, 0);
        in_valid = 1'b1; positional = 8'b0001_0000;
        step();
        chk("bp_first_bin", binary, 4);
        out_ready = 1'b0; positional = 8'b0100_0000;
        #1;
        chk("bp_in_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_hold_bin%0d", i), binary, 4);
            chk($sformatf("bp_hold_vld%0d", i), out_valid, 1);
            chk($sformatf("bp_hold_rdy%0d", i), in_ready, 0);
            chk($sformatf("bp_hold_acc%0d", i), acc_cnt, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", in_ready, 1);
        step();
        chk("bp_new_bin", binary, 6);
        chk("bp_new_acc", acc_cnt, 2);
        in_valid = 1'b0;
        step();
        chk("bp_drain_vld", out_valid, 0);

        // clr colliding with a malformed accept.
        clr = 1'b1;
        step();
        clr = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            positional = (i < 5) ? 8'b0000_0000 : 8'b0000_0001;
            step();
        end
        chk("pre_clr_errcnt", err_cnt, 5);
        chk("pre_clr_acc", acc_cnt, 9);
        clr = 1'b1; positional = 8'b0000_0011;
        step();
        clr = 1'b0;
        chk("coll_errcnt", err_cnt, 1);
        chk("coll_acc", acc_cnt, 1);
        chk("coll_sticky", sticky_err, 1);
        chk("coll_bin", binary, 0);
        chk("coll_err", err, 1);
        chk("coll_vld", out_valid, 1);

        // Saturation: 20 malformed words on top of the current 1/1.
        positional = 8'b1100_0000;
        for (int i = 0; i < 20; i++) step();
        chk("sat_errcnt", err_cnt, 15);
        chk("sat_acc", acc_cnt, 15);
        chk("sat_bin", binary, 6);
        chk("sat_err", err, 1);

        // Reset in the middle of a stalled transfer.
        positional = 8'b0000_1000;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        step();
        chk("mid_hold_bin", binary, 3);
        chk("mid_hold_vld", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy_comb", in_ready, 1);
        step();
        rst_n = 1'b1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_bin", binary, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_sticky", sticky_err, 0);
        chk("mid_rst_errcnt", err_cnt, 0);
        chk("mid_rst_acc", acc_cnt, 0);
        chk("mid_rst_rdy", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oh2b_chk.md
Name: oh2b_chk

Overview:
- Downstream consumer of the b2oh decoder's positional (one-hot) output.
- Registers each one-hot word, encodes it back to binary and flags malformed codes (zero or multiple bits set).
- Keeps saturating error and accepted-word counters for checker/statistics use.
- Connects to neighbouring stages through a valid/ready handshake with 1-cycle latency.

Parameters:
- N, 3, binary width; positional width is 2**N.
- CW, 8, width of err_cnt and acc_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- clr  input  1  synchronous clear of err_cnt, acc_cnt, sticky_err.
- in_valid  input  1  positional word present.
- in_ready  output  1  block can accept a word this cycle.
- positional  input  2**N  one-hot word from b2oh.
- out_valid  output  1  binary/err hold a result.
- out_ready  input  1  downstream takes the result.
- binary  output  N  encoded index.
- err  output  1  current result came from a malformed word.
- sticky_err  output  1  an error occurred since the last reset/clr.
- err_cnt  output  CW  count of malformed words accepted, saturating.
- acc_cnt  output  CW  count of all words accepted, saturating.

Behaviour:
- Reset (rst_n=0 at posedge clk): out_valid=0, binary=0, err=0, sticky_err=0, err_cnt=0, acc_cnt=0. Reset overrides all other inputs, including mid-transfer; the held result is discarded.
- Handshake: in_ready = !out_valid | out_ready (combinational, 1 while reset is asserted). Accept = in_valid & in_ready; transfer out = out_valid & out_ready.
- Latency: a word accepted at edge k is presented on binary/err with out_valid=1 after edge k.
- On accept + transfer in the same cycle, the new result replaces the old one and out_valid stays 1, so full throughput is 1 word/cycle.
- On transfer without accept, out_valid goes to 0.
- While out_valid & !out_ready, binary and err hold stable and in_ready=0.
- Encoding of an accepted word:
  - Exactly one bit set at index k: binary=k, err=0.
  - All zero: binary=0, err=1.
  - Two or more bits set: binary = index of the lowest set bit, err=1.
- Counters, evaluated at each posedge when rst_n=1:
  - clr is applied first: err_cnt, acc_cnt and sticky_err go to 0.
  - The same-cycle accept is then counted on top of the cleared values: acc_cnt+1, plus err_cnt+1 and sticky_err=1 if malformed.
  - So clr together with a malformed accept gives err_cnt=1, acc_cnt=1, sticky_err=1.
- Saturation: both counters stop at 2**CW-1 and do not wrap.
- clr does not affect out_valid, binary or err.
- Inputs are ignored when in_ready=0; a word with in_valid=1 must be held by upstream until accepted.

Test Plan:
- Sweep, N=3, out_ready=1: in_valid=1 with positional 00000001, 00000010 … 10000000 on consecutive cycles -> binary 0..7 one cycle later, err=0 throughout, acc_cnt=8, err_cnt=0, sticky_err=0.
- Malformed words: positional 00000000 -> binary=0, err=1. Then 00100100 -> binary=2, err=1. Result: err_cnt=2, sticky_err=1.
- Backpressure: accept 00010000, then out_ready=0 for 3 cycles while in_valid=1 with 01000000 -> binary holds 4, in_ready=0, acc_cnt=1. When out_ready=1, 01000000 is accepted and binary=6 the next cycle.
- clr collision: err_cnt=5 and acc_cnt=9, then clr=1 in the same cycle as accepting 00000011 -> err_cnt=1, acc_cnt=1, sticky_err=1, binary=0, err=1.
- Saturation, CW=4: 20 malformed words -> err_cnt and acc_cnt stop at 15.
- Reset mid-operation: out_valid=1 holding binary=3 with out_ready=0, then rst_n=0 for one cycle -> out_valid=0, binary=0, err=0, all counters 0, in_ready=1.
